sign_extend: RTL and testbench
==============================

Name: sign_extend

Overview:
- Immediate-field extender for the MIPS datapath. Widens the 16-bit instruction immediate to a 32-bit operand for the ALU B-mux, branch adder and LUI path.
- Provides a combinational result `y` that settles within the same cycle.
- Also provides a registered copy `y_q` with a valid flag, for the pipelined ID/EX boundary.

Parameters:
- IN_W, 16, input immediate width.
- OUT_W, 32, output width; must satisfy OUT_W >= IN_W+2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  IN_W  immediate field (instr[15:0]).
- mode  input  2  extension mode: 00 sign, 01 zero, 10 upper (LUI), 11 branch (sign-extend then <<2).
- in_valid  input  1  qualifies `a`/`mode` for the registered path.
- y  output  OUT_W  combinational extended value.
- y_q  output  OUT_W  registered copy of `y`.
- out_valid  output  1  registered copy of `in_valid`.
- is_neg  output  1  combinational; equals a[IN_W-1].

Behaviour:
- Mode 00 (sign): y = {(OUT_W-IN_W){a[IN_W-1]}, a}. This is the default mode the datapath uses.
  - 000A -> 0000000A
  - FFF6 -> FFFFFFF6
  - 7FFF -> 00007FFF
  - 8000 -> FFFF8000
  - 0000 -> 00000000
- Mode 01 (zero): y = {zeros, a}, used for ANDI/ORI/XORI.
- Mode 10 (upper): y = a placed in the upper bits, lower bits zero. With defaults, y = {a, 16'h0000}.
- Mode 11 (branch): y = sign-extended `a` shifted left 2; the two LSBs are 0 and the top bits drop.
  - 8000 -> FFFE0000
  - 0001 -> 00000004
- `y` and `is_neg` are purely combinational:
  - no clock dependency;
  - valid after any change of `a` or `mode`;
  - unaffected by reset.
- Registered path, on each rising edge of clk:
  - y_q <= in_valid ? y : y_q (holds when in_valid=0);
  - out_valid <= in_valid.
- Latency of the registered path is 1 cycle.
- Reset (rst_n=0) takes effect immediately, without waiting for a clock edge:
  - y_q = 0, out_valid = 0.
- Reset asserted mid-operation discards the pending value. The first capture after release occurs on the first rising edge with rst_n=1 and in_valid=1.
- `mode` and `a` with X or Z values: no requirement. Outputs for these inputs are not checked.
- No internal state other than y_q, out_valid and the optional counter.

Optional Feature:
- Macro: SIGN_EXTEND_NEG_COUNT_EN.
- When defined:
  - adds output neg_count [15:0];
  - increments on each rising edge where in_valid=1 and a[IN_W-1]=1, in any mode;
  - wraps FFFF -> 0000;
  - cleared to 0 by rst_n.
- When undefined:
  - neg_count port and its counter are absent;
  - all other behaviour is identical.

Test Plan:
- Mode 00, apply a=000A, FFF6, 0000, 7FFF, 8000 with 10 ns settle each -> y = 0000000A, FFFFFFF6, 00000000, 00007FFF, FFFF8000; is_neg = 0,1,0,0,1.
- Mode 01 a=8000 -> 00008000. Mode 10 a=1234 -> 12340000. Mode 11 a=FFFF -> FFFFFFFC; a=0001 -> 00000004.
- Registered path:
  - a=FFF6, mode=00, in_valid=1 for one cycle -> next edge y_q=FFFFFFF6, out_valid=1;
  - in_valid=0 the following cycle -> y_q holds, out_valid=0.
- Reset: with y_q nonzero, drive rst_n=0 between clock edges -> y_q=0 and out_valid=0 immediately. After release, the first valid capture occurs on the next edge.
- With SIGN_EXTEND_NEG_COUNT_EN defined:
  - 3 valid negative inputs and 2 valid positive inputs -> neg_count=3;
  - preload to FFFF via repeated stimulus, then one more negative input -> neg_count=0000;
  - rst_n=0 -> neg_count=0.

Source files
------------

// File: rtl/sign_extend.sv
// ----------------------------------------------------------------------------
// sign_extend
//   Immediate-field extender for the MIPS datapath. Widens the instruction
//   immediate to a full operand for the ALU B-mux, the branch adder and the
//   LUI path. A combinational result is provided for same-cycle use, and a
//   registered copy with a valid flag is provided for the ID/EX boundary.
//
// Parameters
//   IN_W      immediate width (default 16)
//   OUT_W     output width (default 32), must be >= IN_W+2
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (registered path only)
//   a          in   immediate field
//   mode       in   00 sign, 01 zero, 10 upper (LUI), 11 branch (sext << 2)
//   in_valid   in   qualifies a/mode for the registered path
//   y          out  combinational extended value
//   y_q        out  registered copy of y, held while in_valid is low
//   out_valid  out  registered copy of in_valid
//   is_neg     out  combinational sign bit of a
//   neg_count  out  (only with SIGN_EXTEND_NEG_COUNT_EN) 16-bit wrapping
//                   count of valid negative immediates
//
// Optional feature macro: SIGN_EXTEND_NEG_COUNT_EN
// ----------------------------------------------------------------------------
module sign_extend #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  a,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic [OUT_W-1:0] y,
    output logic [OUT_W-1:0] y_q,
    output logic             out_valid,
`ifdef SIGN_EXTEND_NEG_COUNT_EN
    output logic [15:0]      neg_count,
`endif
    output logic             is_neg
);

    localparam int EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext_s;
    logic [OUT_W-1:0] zext_s;
    logic [OUT_W-1:0] y_s;
    logic [OUT_W-1:0] y_q_r;
    logic             out_valid_r;

    // Build the candidate extensions and select one by mode.
    always_comb begin
        sext_s = {{EXT_W{a[IN_W-1]}}, a};
        zext_s = {{EXT_W{1'b0}}, a};
        y_s    = sext_s;
        case (mode)
            2'b00:   y_s = sext_s;
            2'b01:   y_s = zext_s;
            2'b10:   y_s = {a, {EXT_W{1'b0}}};
            // Branch offset is a word offset: the two top bits of the
            // sign-extended value are dropped by the shift.
            2'b11:   y_s = {sext_s[OUT_W-3:0], 2'b00};
            default: y_s = sext_s;
        endcase
    end

    assign y      = y_s;
    assign is_neg = a[IN_W-1];

    // Pipeline register: capture y only when qualified, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q_r       <= {OUT_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (in_valid) begin
                y_q_r <= y_s;
            end else begin
                y_q_r <= y_q_r;
            end
            out_valid_r <= in_valid;
        end
    end

    assign y_q       = y_q_r;
    assign out_valid = out_valid_r;

`ifdef SIGN_EXTEND_NEG_COUNT_EN
    logic [15:0] neg_count_r;

    // Count valid negative immediates regardless of mode; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_count_r <= 16'd0;
        end else if (in_valid && a[IN_W-1]) begin
            neg_count_r <= neg_count_r + 16'd1;
        end else begin
            neg_count_r <= neg_count_r;
        end
    end

    assign neg_count = neg_count_r;
`endif

endmodule

// File: tb/tb_sign_extend.sv
// ----------------------------------------------------------------------------
// tb_sign_extend
//   Self-checking bench for sign_extend with default parameters. Expected
//   registered outputs are queued when stimulus is driven and popped when the
//   capturing edge has passed. Define SIGN_EXTEND_NEG_COUNT_EN to also
//   exercise the negative-immediate counter.
// ----------------------------------------------------------------------------
module tb_sign_extend;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [1:0]  mode;
    logic        in_valid;
    logic [31:0] y;
    logic [31:0] y_q;
    logic        out_valid;
    logic        is_neg;
`ifdef SIGN_EXTEND_NEG_COUNT_EN
    logic [15:0] neg_count;
    logic [15:0] exp_cnt;
`endif

    int          tests_run;
    int          tests_failed;
    logic [31:0] exp_q[$];
    logic [31:0] hold_val;

    sign_extend #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .mode      (mode),
        .in_valid  (in_valid),
        .y         (y),
        .y_q       (y_q),
        .out_valid (out_valid),
`ifdef SIGN_EXTEND_NEG_COUNT_EN
        .neg_count (neg_count),
`endif
        .is_neg    (is_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference model of the extender.
    function automatic logic [31:0] model(input logic [15:0] av, input logic [1:0] mv);
        logic signed [31:0] s;
        logic [31:0]        u;
        s = $signed(av);
        u = 32'(av);
        case (mv)
            2'b00:   return s;
            2'b01:   return u;
            2'b10:   return u * 32'd65536;
            2'b11:   return s * 32'sd4;
            default: return 32'h0;
        endcase
    endfunction

    // One clock of registered-path stimulus with scoreboard check after the edge.
    task automatic drive_cycle(input logic [15:0] av, input logic [1:0] mv, input logic v);
        logic [31:0] e;
        @(negedge clk);
        a = av; mode = mv; in_valid = v;
        if (v) exp_q.push_back(model(av, mv));
`ifdef SIGN_EXTEND_NEG_COUNT_EN
        if (v && av[15]) exp_cnt = exp_cnt + 16'd1;
`endif
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== v) begin
            tests_failed++;
            $display("FAIL out_valid: got %b expected %b", out_valid, v);
        end
        if (v) begin
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                e = exp_q.pop_front();
                hold_val = e;
            end
        end
        tests_run++;
        if (y_q !== hold_val) begin
            tests_failed++;
            $display("FAIL y_q: got %h expected %h (a=%h mode=%b v=%b)", y_q, hold_val, av, mv, v);
        end
    endtask

    task automatic check_comb(input logic [15:0] av, input logic [1:0] mv,
                              input logic [31:0] ey, input logic en);
        a = av; mode = mv;
        #10;
        tests_run++;
        if (y !== ey) begin
            tests_failed++;
            $display("FAIL y: got %h expected %h (a=%h mode=%b)", y, ey, av, mv);
        end
        tests_run++;
        if (is_neg !== en) begin
            tests_failed++;
            $display("FAIL is_neg: got %b expected %b (a=%h)", is_neg, en, av);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; a = 16'h0000; mode = 2'b00; in_valid = 1'b0;
        #12;
        tests_run++;
        if (y_q !== 32'h0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got y_q=%h out_valid=%b expected 0/0", y_q, out_valid);
        end
        // Combinational path must work while reset is held.
        check_comb(16'hFFF6, 2'b00, 32'hFFFFFFF6, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        hold_val = 32'h0;
`ifdef SIGN_EXTEND_NEG_COUNT_EN
        exp_cnt = 16'd0;
        tests_run++;
        if (neg_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL neg_count_reset: got %h expected 0000", neg_count);
        end
`endif
    endtask

    task automatic test_sign_mode;
        check_comb(16'h000A, 2'b00, 32'h0000000A, 1'b0);
        check_comb(16'hFFF6, 2'b00, 32'hFFFFFFF6, 1'b1);
        check_comb(16'h0000, 2'b00, 32'h00000000, 1'b0);
        check_comb(16'h7FFF, 2'b00, 32'h00007FFF, 1'b0);
        check_comb(16'h8000, 2'b00, 32'hFFFF8000, 1'b1);
    endtask

    task automatic test_other_modes;
        check_comb(16'h8000, 2'b01, 32'h00008000, 1'b1);
        check_comb(16'h1234, 2'b10, 32'h12340000, 1'b0);
        check_comb(16'hFFFF, 2'b11, 32'hFFFFFFFC, 1'b1);
        check_comb(16'h0001, 2'b11, 32'h00000004, 1'b0);
        check_comb(16'h8000, 2'b11, 32'hFFFE0000, 1'b1);
        check_comb(16'hFFFF, 2'b10, 32'hFFFF0000, 1'b1);
    endtask

    task automatic test_random_comb;
        logic [15:0] av;
        logic [1:0]  mv;
        for (int i = 0; i < 24; i++) begin
            av = 16'($urandom);
            mv = 2'($urandom_range(3, 0));
            check_comb(av, mv, model(av, mv), av[15]);
        end
    endtask

    task automatic test_registered;
        drive_cycle(16'hFFF6, 2'b00, 1'b1);
        drive_cycle(16'h0005, 2'b01, 1'b0);
        drive_cycle(16'h1234, 2'b10, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 30; i++) begin
            drive_cycle(16'($urandom), 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end
        drive_cycle(16'h7FFF, 2'b11, 1'b1);
        drive_cycle(16'h8001, 2'b01, 1'b1);
    endtask

    task automatic test_reset_mid;
        drive_cycle(16'h8000, 2'b00, 1'b1);
        @(negedge clk);
        a = 16'h1234; mode = 2'b01; in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (y_q !== 32'h0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: got y_q=%h out_valid=%b expected 0/0", y_q, out_valid);
        end
        exp_q.delete();
        hold_val = 32'h0;
`ifdef SIGN_EXTEND_NEG_COUNT_EN
        exp_cnt = 16'd0;
        tests_run++;
        if (neg_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL neg_count_async_reset: got %h expected 0000", neg_count);
        end
`endif
        @(posedge clk);
        #1;
        tests_run++;
        if (y_q !== 32'h0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: got y_q=%h out_valid=%b expected 0/0", y_q, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (y_q !== 32'h00001234 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_capture: got y_q=%h out_valid=%b expected 00001234/1", y_q, out_valid);
        end
        hold_val = 32'h00001234;
        drive_cycle(16'hABCD, 2'b00, 1'b0);
    endtask

`ifdef SIGN_EXTEND_NEG_COUNT_EN
    task automatic test_neg_count;
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        exp_cnt = 16'd0; hold_val = 32'h0; exp_q.delete();
        drive_cycle(16'h8000, 2'b00, 1'b1);
        drive_cycle(16'h0001, 2'b01, 1'b1);
        drive_cycle(16'hFFFF, 2'b10, 1'b1);
        drive_cycle(16'hC000, 2'b11, 1'b0);
        drive_cycle(16'h7FFF, 2'b11, 1'b1);
        drive_cycle(16'h9000, 2'b11, 1'b1);
        tests_run++;
        if (neg_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL neg_count_3: got %h expected 0003", neg_count);
        end
        // Preload to FFFF.
        for (int i = 0; i < 65532; i++) begin
            @(negedge clk);
            a = 16'hF000; mode = 2'($urandom_range(3, 0)); in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        hold_val = model(16'hF000, mode);
        tests_run++;
        if (neg_count !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL neg_count_ffff: got %h expected FFFF", neg_count);
        end
        exp_cnt = 16'hFFFF;
        drive_cycle(16'h8888, 2'b00, 1'b1);
        tests_run++;
        if (neg_count !== 16'h0000 || neg_count !== exp_cnt) begin
            tests_failed++;
            $display("FAIL neg_count_wrap: got %h expected 0000", neg_count);
        end
        drive_cycle(16'h8888, 2'b00, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (neg_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL neg_count_rst: got %h expected 0000", neg_count);
        end
        rst_n = 1'b1;
        hold_val = 32'h0; exp_cnt = 16'd0;
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        hold_val     = 32'h0;
`ifdef SIGN_EXTEND_NEG_COUNT_EN
        exp_cnt      = 16'd0;
`endif
        test_reset();
        test_sign_mode();
        test_other_modes();
        test_random_comb();
        test_registered();
        test_back_to_back();
        test_reset_mid();
`ifdef SIGN_EXTEND_NEG_COUNT_EN
        test_neg_count();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
